// File: rtl/prio_q_sched_if.sv
// Requester, consumer and heap-side signals of the priority-queue scheduler, bundled.
// The slave modport is the scheduler's view; the master modport is its environment's view.
interface prio_q_sched_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       enq_req;
    logic [N_REQ*WIDTH-1:0] enq_data;
    logic [N_REQ-1:0]       enq_ack;
    logic                   deq_req;
    logic                   deq_valid;
    logic [WIDTH-1:0]       deq_data;
    logic                   q_enq;
    logic                   q_deq;
    logic [WIDTH-1:0]       q_inp_data;
    logic [WIDTH-1:0]       q_out_data;
    logic                   full;
    logic                   empty;
    logic [DEPTH-1:0]       occupancy;
    logic [31:0]            stat_enq;
    logic [31:0]            stat_deq;
    logic [31:0]            stat_stall;

    modport slave (
        input  enq_req, enq_data, deq_req, q_out_data,
        output enq_ack, deq_valid, deq_data, q_enq, q_deq, q_inp_data,
        output full, empty, occupancy, stat_enq, stat_deq, stat_stall
    );

    modport master (
        output enq_req, enq_data, deq_req, q_out_data,
        input  enq_ack, deq_valid, deq_data, q_enq, q_deq, q_inp_data,
        input  full, empty, occupancy, stat_enq, stat_deq, stat_stall
    );
endinterface

// File: rtl/prio_q_sched.sv
// Scheduler in front of a min-heap: round-robin enqueue arbitration, dequeue priority, paced strobes.
// Optional macro PRIO_Q_SCHED_STATS_EN enables the enqueue/dequeue/stall counters.
module prio_q_sched #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int N_REQ = 4,
    parameter int GAP   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_q_sched_if.slave bus
);
    localparam int               PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [DEPTH-1:0] CAP      = {DEPTH{1'b1}};
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(N_REQ - 1);
    localparam logic [1:0]       GAP_LOAD = 2'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_ENQ, ST_DEQ, ST_GAP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         gap_cnt_q, gap_cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DEPTH-1:0]   occupancy_q, occupancy_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               q_enq_q, q_enq_d;
    logic               q_deq_q, q_deq_d;
    logic [N_REQ-1:0]   enq_ack_q, enq_ack_d;
    logic [WIDTH-1:0]   q_inp_data_q, q_inp_data_d;
    logic               deq_valid_q, deq_valid_d;
    logic [WIDTH-1:0]   deq_data_q, deq_data_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;

    // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && bus.enq_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        ptr_d        = ptr_q;
        occupancy_d  = occupancy_q;
        q_enq_d      = 1'b0;
        q_deq_d      = 1'b0;
        enq_ack_d    = '0;
        q_inp_data_d = q_inp_data_q;
        deq_valid_d  = 1'b0;
        deq_data_d   = deq_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.deq_req && !empty_q) begin
                    state_d     = ST_DEQ;
                    q_deq_d     = 1'b1;
                    occupancy_d = occupancy_q - 1'b1;
                end else if (win_found && !full_q) begin
                    state_d            = ST_ENQ;
                    q_enq_d            = 1'b1;
                    enq_ack_d[win_idx] = 1'b1;
                    q_inp_data_d       = bus.enq_data[int'(win_idx) * WIDTH +: WIDTH];
                    occupancy_d        = occupancy_q + 1'b1;
                    ptr_d              = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
                end
            end
            ST_ENQ, ST_DEQ: begin
                // Heap root is still the pre-dequeue minimum during the strobe cycle.
                if (state_q == ST_DEQ) begin
                    deq_valid_d = 1'b1;
                    deq_data_d  = bus.q_out_data;
                end
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        full_d  = (occupancy_d == CAP);
        empty_d = (occupancy_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= 2'd0;
            ptr_q        <= '0;
            occupancy_q  <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            q_enq_q      <= 1'b0;
            q_deq_q      <= 1'b0;
            enq_ack_q    <= '0;
            q_inp_data_q <= '0;
            deq_valid_q  <= 1'b0;
            deq_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            ptr_q        <= ptr_d;
            occupancy_q  <= occupancy_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            q_enq_q      <= q_enq_d;
            q_deq_q      <= q_deq_d;
            enq_ack_q    <= enq_ack_d;
            q_inp_data_q <= q_inp_data_d;
            deq_valid_q  <= deq_valid_d;
            deq_data_q   <= deq_data_d;
        end
    end

    assign bus.q_enq      = q_enq_q;
    assign bus.q_deq      = q_deq_q;
    assign bus.enq_ack    = enq_ack_q;
    assign bus.q_inp_data = q_inp_data_q;
    assign bus.deq_valid  = deq_valid_q;
    assign bus.deq_data   = deq_data_q;
    assign bus.occupancy  = occupancy_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;

`ifdef PRIO_Q_SCHED_STATS_EN
    logic [31:0] stat_enq_q, stat_enq_d;
    logic [31:0] stat_deq_q, stat_deq_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic        grant;

    // A grant is exactly an IDLE cycle that leaves IDLE.
    assign grant = (state_q == ST_IDLE) && (state_d != ST_IDLE);

    always_comb begin
        stat_enq_d   = stat_enq_q + {31'd0, q_enq_d};
        stat_deq_d   = stat_deq_q + {31'd0, q_deq_d};
        stat_stall_d = stat_stall_q + {31'd0, ((|bus.enq_req) || bus.deq_req) && !grant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_enq_q   <= '0;
            stat_deq_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_enq_q   <= stat_enq_d;
            stat_deq_q   <= stat_deq_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign bus.stat_enq   = stat_enq_q;
    assign bus.stat_deq   = stat_deq_q;
    assign bus.stat_stall = stat_stall_q;
`else
    assign bus.stat_enq   = '0;
    assign bus.stat_deq   = '0;
    assign bus.stat_stall = '0;
`endif
endmodule

// File: tb/tb_prio_q_sched.sv
// Bench for prio_q_sched: queue-based heap environment, cycle-level reference model, directed vectors.
module tb_prio_q_sched;
    localparam int WIDTH = 32;
    localparam int DEPTH = 5;
    localparam int N_REQ = 4;
    localparam int GAP   = 1;
    localparam int CAP   = (1 << DEPTH) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prio_q_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) bus ();

    prio_q_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int min_pos(input logic [WIDTH-1:0] q[$]);
        int m = 0;
        for (int k = 1; k < q.size(); k++) if (q[k] < q[m]) m = k;
        return m;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] req, input int p);
        for (int k = 0; k < N_REQ; k++) if (req[(p + k) % N_REQ]) return (p + k) % N_REQ;
        return 0;
    endfunction

    // Heap environment: an operation strobed in cycle t takes effect on the root from cycle t+1.
    initial begin
        logic [WIDTH-1:0] heap[$];
        logic             h_enq, h_deq;
        logic [WIDTH-1:0] h_data;
        int               m;
        h_enq = 1'b0; h_deq = 1'b0; h_data = '0;
        bus.q_out_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                heap.delete();
                h_enq = 1'b0;
                h_deq = 1'b0;
            end else begin
                if (h_enq) heap.push_back(h_data);
                if (h_deq && heap.size() > 0) begin
                    m = min_pos(heap);
                    heap.delete(m);
                end
                h_enq  = bus.q_enq;
                h_deq  = bus.q_deq;
                h_data = bus.q_inp_data;
            end
            bus.q_out_data = (heap.size() > 0) ? heap[min_pos(heap)] : '0;
        end
    end

    // Reference model and per-cycle compare. A decision is taken at the end of every IDLE cycle,
    // and a cycle is IDLE once GAP+1 cycles have elapsed since the last strobe cycle.
    initial begin
        logic [N_REQ-1:0]       p_enq;
        logic [N_REQ*WIDTH-1:0] p_data;
        logic                   p_deq, p_idle;
        logic                   ex_enq, ex_deq, ex_dv;
        logic [N_REQ-1:0]       ex_ack;
        logic [WIDTH-1:0]       ex_dd;
        logic [WIDTH-1:0]       mq[$];
        logic [13:0]            rst_vec;
        int                     cnt, ptr, win, since, k;
        p_enq = '0; p_data = '0; p_deq = 1'b0; p_idle = 1'b0;
        ex_dv = 1'b0; ex_dd = '0; cnt = 0; ptr = 0; since = GAP;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rst_vec = {bus.occupancy, bus.empty, bus.full, bus.q_enq, bus.q_deq, bus.enq_ack, bus.deq_valid};
                chk("reset_ctrl", 64'(rst_vec), 64'(14'b00000_1_0_0_0_0000_0));
                chk("reset_data", {bus.deq_data, bus.q_inp_data}, 64'd0);
                mq.delete();
                cnt = 0; ptr = 0; since = GAP; p_idle = 1'b0; ex_dv = 1'b0;
            end else begin
                ex_enq = 1'b0; ex_deq = 1'b0; ex_ack = '0; win = 0;
                if (p_idle) begin
                    if (p_deq && cnt > 0) begin
                        ex_deq = 1'b1;
                    end else if (p_enq != '0 && cnt < CAP) begin
                        ex_enq = 1'b1;
                        win = rr_pick(p_enq, ptr);
                        ex_ack[win] = 1'b1;
                    end
                end
                chk("q_enq", 64'(bus.q_enq), 64'(ex_enq));
                chk("q_deq", 64'(bus.q_deq), 64'(ex_deq));
                chk("enq_ack", 64'(bus.enq_ack), 64'(ex_ack));
                if (ex_enq) chk("q_inp_data", 64'(bus.q_inp_data), 64'(p_data[win*WIDTH +: WIDTH]));
                chk("deq_valid", 64'(bus.deq_valid), 64'(ex_dv));
                if (ex_dv) chk("deq_data", 64'(bus.deq_data), 64'(ex_dd));
                ex_dv = 1'b0;
                if (ex_enq) begin
                    cnt++;
                    mq.push_back(p_data[win*WIDTH +: WIDTH]);
                    ptr = (win + 1) % N_REQ;
                end
                if (ex_deq) begin
                    cnt--;
                    k = min_pos(mq);
                    ex_dd = mq[k];
                    mq.delete(k);
                    ex_dv = 1'b1;
                end
                chk("occupancy", 64'(bus.occupancy), 64'(cnt));
                chk("empty", 64'(bus.empty), 64'(cnt == 0));
                chk("full", 64'(bus.full), 64'(cnt == CAP));
                since  = (ex_enq || ex_deq) ? 0 : since + 1;
                p_idle = (since >= GAP + 1);
            end
            p_enq  = bus.enq_req;
            p_data = bus.enq_data;
            p_deq  = bus.deq_req;
        end
    end

    task automatic drive_point();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.enq_req = '0;
        bus.deq_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_enq(input int i, input logic [WIDTH-1:0] d);
        int n = 0;
        bus.enq_data[i*WIDTH +: WIDTH] = d;
        bus.enq_req[i] = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.enq_ack[i] && n < 50);
        chk("enq_ack_seen", 64'(bus.enq_ack[i]), 64'd1);
        drive_point();
        bus.enq_req[i] = 1'b0;
    endtask

    task automatic do_deq(input string name, input logic [WIDTH-1:0] exp);
        int n = 0;
        bus.deq_req = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.deq_valid && n < 50);
        chk({name, "_valid"}, 64'(bus.deq_valid), 64'd1);
        chk(name, 64'(bus.deq_data), 64'(exp));
        drive_point();
        bus.deq_req = 1'b0;
    endtask

    initial begin
        int got_i[5];
        int got_t[5];
        int nacks, cyc, n;
        rst_n = 1'b0;
        bus.enq_req = '0; bus.enq_data = '0; bus.deq_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stat_enq", 64'(bus.stat_enq), 64'd0);
        chk("rst_stat_deq", 64'(bus.stat_deq), 64'd0);
        chk("rst_stat_stall", 64'(bus.stat_stall), 64'd0);
        drive_point();

        // First grant right after reset release
        bus.enq_data[0 +: WIDTH] = 32'h10;
        bus.enq_req = 4'b0001;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_q_enq", 64'(bus.q_enq), 64'd1);
        chk("t1_q_inp_data", 64'(bus.q_inp_data), 64'h10);
        chk("t1_enq_ack", 64'(bus.enq_ack), 64'b0001);
        chk("t1_occupancy", 64'(bus.occupancy), 64'd1);
        chk("t1_empty", 64'(bus.empty), 64'd0);
        drive_point();
        bus.enq_req = '0;
        do_deq("t1_deq", 32'h10);

        // Minimum-first ordering
        do_enq(0, 32'h30);
        do_enq(1, 32'h05);
        do_enq(2, 32'h20);
        do_deq("t2_deq0", 32'h05);
        do_deq("t2_deq1", 32'h20);
        do_deq("t2_deq2", 32'h30);
        @(negedge clk);
        chk("t2_empty_end", 64'(bus.empty), 64'd1);
        drive_point();

        // Round-robin with all requesters held, starting from a fresh pointer
        do_reset();
        for (int i = 0; i < N_REQ; i++) bus.enq_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
        bus.enq_req = 4'b1111;
        rst_n = 1'b1;
        nacks = 0; cyc = 0;
        for (int k = 0; k < 5; k++) begin got_i[k] = -1; got_t[k] = 0; end
        while (nacks < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.enq_ack != '0) begin
                for (int i = 0; i < N_REQ; i++) if (bus.enq_ack[i]) got_i[nacks] = i;
                got_t[nacks] = cyc;
                nacks++;
            end
        end
        chk("t3_ack_count", 64'(nacks), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk("t3_ack_order", 64'(got_i[k]), 64'(k % N_REQ));
            if (k > 0) chk("t3_ack_spacing", 64'(got_t[k] - got_t[k-1]), 64'd3);
        end

        // Fill to capacity, observe the enqueue stall, then a dequeue wins while full
        n = 0;
        while (bus.occupancy != 5'd31 && n < 200) begin @(negedge clk); n++; end
        chk("t4_full", 64'(bus.full), 64'd1);
        repeat (6) begin
            @(negedge clk);
            chk("t4_stall_ack", 64'(bus.enq_ack), 64'd0);
        end
        drive_point();
        bus.deq_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.q_deq && !bus.q_enq && n < 20);
        chk("t4_deq_first", 64'({bus.q_enq, bus.q_deq}), 64'b01);
        @(negedge clk);
        chk("t4_deq_valid", 64'(bus.deq_valid), 64'd1);
        chk("t4_deq_data", 64'(bus.deq_data), 64'hA0);
        chk("t4_occupancy", 64'(bus.occupancy), 64'd30);
        chk("t4_full_drop", 64'(bus.full), 64'd0);
        drive_point();
        bus.deq_req = 1'b0;
        bus.enq_req = '0;

        // Dequeue request while empty is never served
        do_reset();
        bus.deq_req = 1'b1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t5_no_deq", 64'({bus.q_deq, bus.deq_valid}), 64'd0);
            chk("t5_empty", 64'(bus.empty), 64'd1);
        end
        drive_point();
        bus.deq_req = 1'b0;

        // Reset during the dequeue strobe abandons the operation
        do_enq(0, 32'h55);
        bus.deq_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.q_deq && n < 20);
        chk("t6_q_deq_seen", 64'(bus.q_deq), 64'd1);
        #1;
        rst_n = 1'b0;
        bus.deq_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t6_no_valid", 64'(bus.deq_valid), 64'd0);
        end
        chk("t6_occupancy", 64'(bus.occupancy), 64'd0);
        chk("t6_stat_enq", 64'(bus.stat_enq), 64'd0);
        chk("t6_stat_deq", 64'(bus.stat_deq), 64'd0);
        chk("t6_stat_stall", 64'(bus.stat_stall), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
